pong_game_ctrl: RTL and testbench
=================================

Name: pong_game_ctrl

Overview:
- Top-level game sequencer for Pong: start/serve/play/point/game-over flow.
- Sits between the frame timer, the ball mover and the score block.
- Gates ball motion, recentres the ball before each serve and picks serve direction.
- Detects a ball reaching the left or right edge, emits one-cycle point strobes to the score block, and declares a winner from the returned scores.

Parameters:
- SCREEN_W, 640, horizontal active pixels.
- BALL_SIZE, 8, ball width in pixels.
- WIN_SCORE, 9, score that ends the game (must be <= 15).
- SERVE_DELAY, 60, frame ticks spent in SERVE before the ball is released.
- POINT_HOLD, 30, frame ticks the ball stays frozen after a point.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- start  in  1  start button, level; rising edge detected internally
- frame_tick  in  1  one-cycle pulse per video frame
- ball_x  in  10  ball left x coordinate
- p1_score  in  4  left player score from score block
- p2_score  in  4  right player score from score block
- ball_run  out  1  ball mover enable
- ball_reset  out  1  level; holds ball at centre
- serve_dir  out  1  1 = serve right, 0 = serve left
- score_clear  out  1  one-cycle pulse; score block clears both scores
- point_p1  out  1  one-cycle pulse; p1 (left) scores
- point_p2  out  1  one-cycle pulse; p2 (right) scores
- winner  out  2  00 none, 01 p1, 10 p2
- state  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4

Behaviour:
- All flops update on posedge clk. reset==0 forces:
  - state=IDLE, ball_run=0, ball_reset=1, serve_dir=1, score_clear=0, point_p1=0, point_p2=0, winner=00.
  - Frame counter 0, start_q 0.
  - Reset mid-game behaves identically; no pending strobe survives.
- start_rise = start & ~start_q; start_q is registered each cycle.
- Frame counter (6+ bits, sized for max(SERVE_DELAY, POINT_HOLD)):
  - Cleared on every state change.
  - Increments only on frame_tick.
- IDLE: ball_reset=1, ball_run=0. On start_rise: score_clear pulses 1 cycle, winner=00, serve_dir=1, go to SERVE.
- SERVE: ball_reset=1, ball_run=0. When counter reaches SERVE_DELAY-1 and frame_tick is high, go to PLAY next cycle.
- PLAY: ball_reset=0, ball_run=1. Edge checks are on registered state:
  - ball_x == 0 → point_p2 pulses; serve_dir←0 (serve toward loser p1); go to POINT.
  - ball_x >= SCREEN_W-BALL_SIZE → point_p1 pulses; serve_dir←1; go to POINT.
  - Strobe asserts in the same cycle state becomes POINT (registered output), exactly one cycle.
  - Left check has priority (conditions are disjoint for legal parameters).
- POINT: ball_run=0, ball_reset=0 (ball frozen at edge). After POINT_HOLD frame ticks (counter == POINT_HOLD-1 with frame_tick):
  - p1_score >= WIN_SCORE → OVER, winner=01.
  - Else p2_score >= WIN_SCORE → OVER, winner=10.
  - Else → SERVE.
  - Scores are sampled here, long after the strobe, so score-block latency of 1–2 cycles is tolerated.
- OVER: ball_run=0, ball_reset=1, winner held. start_rise → score_clear pulse, winner=00, serve_dir=1, SERVE.
- start_rise outside IDLE/OVER is ignored.
- frame_tick coincident with a state change is not counted in the new state.
- Outputs ball_run, ball_reset and winner are registered and decoded from state; no combinational path from inputs to outputs.
- Counters never wrap: equality to limit-1 causes exit. Parameters of 0 are illegal.

Test Plan (SERVE_DELAY=2, POINT_HOLD=3, WIN_SCORE=3, frame_tick every 4 cycles):
- Reset: hold reset=0 for 3 cycles → state=0, ball_reset=1, ball_run=0, serve_dir=1, winner=00, all strobes 0.
- Start: pulse start for 1 cycle in IDLE → score_clear high exactly 1 cycle, state=1; after 2 frame ticks state=2 and ball_run=1.
- Right-edge point: in PLAY, ramp ball_x 620→635 by 5/cycle → point_p1 single pulse at ball_x=635 (>=632), state=3, serve_dir=1, ball_run=0. After 3 ticks state=1 (scores 1/0).
- Left-edge point: in PLAY, drive ball_x=0 → point_p2 single pulse, serve_dir=0. Hold start high throughout → no effect, state stays in the PLAY→POINT→SERVE path.
- Game over: model the score block so p1_score reaches 3; after POINT_HOLD → state=4, winner=01, ball_reset=1. New start edge → score_clear pulse, winner=00, state=1.
- Reset mid-PLAY: drive reset=0 on the same cycle ball_x=0 → no point_p2 pulse, state=0 next cycle.

Source files
------------

// File: rtl/pong_game_if.sv
// Game controller bus: frame/ball/score inputs in, ball-mover and score-block controls out.
// Master drives the inputs (environment side); slave is the controller.
interface pong_game_if;
  logic       start;
  logic       frame_tick;
  logic [9:0] ball_x;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic       ball_run;
  logic       ball_reset;
  logic       serve_dir;
  logic       score_clear;
  logic       point_p1;
  logic       point_p2;
  logic [1:0] winner;
  logic [2:0] state;

  modport master (
    output start, frame_tick, ball_x, p1_score, p2_score,
    input  ball_run, ball_reset, serve_dir, score_clear, point_p1, point_p2, winner, state
  );

  modport slave (
    input  start, frame_tick, ball_x, p1_score, p2_score,
    output ball_run, ball_reset, serve_dir, score_clear, point_p1, point_p2, winner, state
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong sequencer: IDLE/SERVE/PLAY/POINT/OVER with serve delay, point hold and winner decode.
// All outputs registered, one cycle after the causing input; no backpressure (strobes are fire-and-forget).
module pong_game_ctrl #(
  parameter int SCREEN_W    = 640,
  parameter int BALL_SIZE   = 8,
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_DELAY = 60,
  parameter int POINT_HOLD  = 30
) (
  input  logic        clk,
  input  logic        reset,
  pong_game_if.slave  bus
);

  localparam int MAX_LIM = (SERVE_DELAY > POINT_HOLD) ? SERVE_DELAY : POINT_HOLD;
  localparam int CNT_W   = ($clog2(MAX_LIM) < 6) ? 6 : $clog2(MAX_LIM);

  localparam logic [9:0]       EDGE_X    = 10'(SCREEN_W - BALL_SIZE);
  localparam logic [3:0]       WIN_S     = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0] SERVE_END = CNT_W'(SERVE_DELAY - 1);
  localparam logic [CNT_W-1:0] HOLD_END  = CNT_W'(POINT_HOLD - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t           st;
  logic [CNT_W-1:0] cnt;
  logic             start_q;
  logic             ball_run;
  logic             ball_reset;
  logic             serve_dir;
  logic             score_clear;
  logic             point_p1;
  logic             point_p2;
  logic [1:0]       winner;

  wire start_rise = bus.start & ~start_q;

  // Every transition clears cnt and loads the new state's ball controls in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      st          <= IDLE;
      cnt         <= '0;
      start_q     <= 1'b0;
      ball_run    <= 1'b0;
      ball_reset  <= 1'b1;
      serve_dir   <= 1'b1;
      score_clear <= 1'b0;
      point_p1    <= 1'b0;
      point_p2    <= 1'b0;
      winner      <= 2'b00;
    end else begin
      start_q     <= bus.start;
      score_clear <= 1'b0;
      point_p1    <= 1'b0;
      point_p2    <= 1'b0;
      case (st)
        IDLE, OVER: begin
          if (start_rise) begin
            st          <= SERVE;
            cnt         <= '0;
            score_clear <= 1'b1;
            winner      <= 2'b00;
            serve_dir   <= 1'b1;
            ball_run    <= 1'b0;
            ball_reset  <= 1'b1;
          end
        end
        SERVE: begin
          if (bus.frame_tick) begin
            if (cnt == SERVE_END) begin
              st         <= PLAY;
              cnt        <= '0;
              ball_run   <= 1'b1;
              ball_reset <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        PLAY: begin
          if (bus.ball_x == 10'd0) begin
            st        <= POINT;
            cnt       <= '0;
            point_p2  <= 1'b1;
            serve_dir <= 1'b0;
            ball_run  <= 1'b0;
          end else if (bus.ball_x >= EDGE_X) begin
            st        <= POINT;
            cnt       <= '0;
            point_p1  <= 1'b1;
            serve_dir <= 1'b1;
            ball_run  <= 1'b0;
          end
        end
        POINT: begin
          if (bus.frame_tick) begin
            if (cnt == HOLD_END) begin
              cnt        <= '0;
              ball_reset <= 1'b1;
              if (bus.p1_score >= WIN_S) begin
                st     <= OVER;
                winner <= 2'b01;
              end else if (bus.p2_score >= WIN_S) begin
                st     <= OVER;
                winner <= 2'b10;
              end else begin
                st <= SERVE;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          st         <= IDLE;
          cnt        <= '0;
          ball_run   <= 1'b0;
          ball_reset <= 1'b1;
        end
      endcase
    end
  end

  assign bus.state       = st;
  assign bus.ball_run    = ball_run;
  assign bus.ball_reset  = ball_reset;
  assign bus.serve_dir   = serve_dir;
  assign bus.score_clear = score_clear;
  assign bus.point_p1    = point_p1;
  assign bus.point_p2    = point_p2;
  assign bus.winner      = winner;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: rule-level reference model checked every cycle plus directed literal checks.
module tb_pong_game_ctrl;
  localparam int SCREEN_W    = 640;
  localparam int BALL_SIZE   = 8;
  localparam int WIN_SCORE   = 3;
  localparam int SERVE_DELAY = 2;
  localparam int POINT_HOLD  = 3;

  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_OVER = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;
  int   cyc = 0;

  pong_game_if bus();

  pong_game_ctrl #(
    .SCREEN_W(SCREEN_W), .BALL_SIZE(BALL_SIZE), .WIN_SCORE(WIN_SCORE),
    .SERVE_DELAY(SERVE_DELAY), .POINT_HOLD(POINT_HOLD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Frame tick every 4 cycles
  always @(negedge clk) begin
    cyc++;
    bus.frame_tick = (cyc % 4 == 0);
  end

  // Score block: counts strobes one cycle late, cleared by score_clear
  always @(posedge clk) begin
    if (!reset) begin
      bus.p1_score <= 4'd0;
      bus.p2_score <= 4'd0;
    end else if (bus.score_clear) begin
      bus.p1_score <= 4'd0;
      bus.p2_score <= 4'd0;
    end else begin
      if (bus.point_p1) bus.p1_score <= bus.p1_score + 4'd1;
      if (bus.point_p2) bus.p2_score <= bus.p2_score + 4'd1;
    end
  end

  // Reference model: game phase plus frames-elapsed count; ball controls derived from phase
  int       m_state = S_IDLE;
  int       m_ticks = 0;
  bit       m_start_q = 0, m_dir = 1, m_clr = 0, m_p1 = 0, m_p2 = 0;
  bit [1:0] m_win = 0;

  always @(posedge clk) begin
    if (!reset) begin
      m_state <= S_IDLE; m_ticks <= 0; m_start_q <= 0; m_dir <= 1;
      m_clr <= 0; m_p1 <= 0; m_p2 <= 0; m_win <= 0;
    end else begin
      m_start_q <= bus.start;
      m_clr <= 0; m_p1 <= 0; m_p2 <= 0;
      case (m_state)
        S_IDLE, S_OVER:
          if (bus.start && !m_start_q) begin
            m_state <= S_SERVE; m_ticks <= 0; m_clr <= 1; m_win <= 0; m_dir <= 1;
          end
        S_SERVE:
          if (bus.frame_tick) begin
            if (m_ticks + 1 == SERVE_DELAY) begin m_state <= S_PLAY; m_ticks <= 0; end
            else m_ticks <= m_ticks + 1;
          end
        S_PLAY:
          if (int'(bus.ball_x) == 0) begin
            m_state <= S_POINT; m_ticks <= 0; m_p2 <= 1; m_dir <= 0;
          end else if (int'(bus.ball_x) + BALL_SIZE >= SCREEN_W) begin
            m_state <= S_POINT; m_ticks <= 0; m_p1 <= 1; m_dir <= 1;
          end
        S_POINT:
          if (bus.frame_tick) begin
            if (m_ticks + 1 == POINT_HOLD) begin
              m_ticks <= 0;
              if (int'(bus.p1_score) >= WIN_SCORE) begin m_state <= S_OVER; m_win <= 2'b01; end
              else if (int'(bus.p2_score) >= WIN_SCORE) begin m_state <= S_OVER; m_win <= 2'b10; end
              else m_state <= S_SERVE;
            end else m_ticks <= m_ticks + 1;
          end
        default: m_state <= S_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("state",       int'(bus.state),       m_state);
      check("ball_run",    int'(bus.ball_run),    int'(m_state == S_PLAY));
      check("ball_reset",  int'(bus.ball_reset),  int'(m_state inside {S_IDLE, S_SERVE, S_OVER}));
      check("serve_dir",   int'(bus.serve_dir),   int'(m_dir));
      check("score_clear", int'(bus.score_clear), int'(m_clr));
      check("point_p1",    int'(bus.point_p1),    int'(m_p1));
      check("point_p2",    int'(bus.point_p2),    int'(m_p2));
      check("winner",      int'(bus.winner),      int'(m_win));
    end
  end

  task automatic wait_state(input int s, input string name);
    int n;
    n = 0;
    while (int'(bus.state) != s && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(bus.state), s);
  endtask

  task automatic right_point(input string tag);
    wait_state(S_PLAY, {tag, "_wait_play"});
    check({tag, "_run"}, int'(bus.ball_run), 1);
    for (int v = 620; v <= 635; v += 5) begin
      @(negedge clk);
      bus.ball_x = 10'(v);
    end
    @(negedge clk);
    check({tag, "_p1_pulse"}, int'(bus.point_p1), 1);
    check({tag, "_state_point"}, int'(bus.state), S_POINT);
    check({tag, "_dir"}, int'(bus.serve_dir), 1);
    check({tag, "_run_off"}, int'(bus.ball_run), 0);
    bus.ball_x = 10'd320;
    @(negedge clk);
    check({tag, "_p1_single"}, int'(bus.point_p1), 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.ball_x = 10'd320;
    bus.frame_tick = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_state", int'(bus.state), S_IDLE);
    check("rst_ball_reset", int'(bus.ball_reset), 1);
    check("rst_ball_run", int'(bus.ball_run), 0);
    check("rst_serve_dir", int'(bus.serve_dir), 1);
    check("rst_winner", int'(bus.winner), 0);
    check("rst_strobes", int'({bus.score_clear, bus.point_p1, bus.point_p2}), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("start_state", int'(bus.state), S_SERVE);
    check("start_clear", int'(bus.score_clear), 1);
    @(negedge clk);
    check("start_clear_single", int'(bus.score_clear), 0);

    right_point("rp1");
    wait_state(S_SERVE, "rp1_back_serve");
    check("rp1_score", int'(bus.p1_score), 1);

    bus.start = 1'b1;
    wait_state(S_PLAY, "lp_wait_play");
    @(negedge clk);
    bus.ball_x = 10'd0;
    @(negedge clk);
    check("lp_p2_pulse", int'(bus.point_p2), 1);
    check("lp_dir", int'(bus.serve_dir), 0);
    check("lp_state", int'(bus.state), S_POINT);
    bus.ball_x = 10'd320;
    @(negedge clk);
    check("lp_p2_single", int'(bus.point_p2), 0);
    wait_state(S_SERVE, "lp_back_serve");
    bus.start = 1'b0;

    right_point("rp2");
    wait_state(S_SERVE, "rp2_back_serve");
    right_point("rp3");
    wait_state(S_OVER, "over_state");
    check("over_winner", int'(bus.winner), 1);
    check("over_ball_reset", int'(bus.ball_reset), 1);
    repeat (3) @(negedge clk);
    check("over_held", int'(bus.state), S_OVER);

    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("restart_clear", int'(bus.score_clear), 1);
    check("restart_winner", int'(bus.winner), 0);
    check("restart_state", int'(bus.state), S_SERVE);

    wait_state(S_PLAY, "mid_wait_play");
    @(negedge clk);
    bus.ball_x = 10'd0;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_state", int'(bus.state), S_IDLE);
    check("mid_rst_no_p2", int'(bus.point_p2), 0);
    check("mid_rst_ball_reset", int'(bus.ball_reset), 1);
    reset = 1'b1;
    bus.ball_x = 10'd320;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
